// File: rtl/mod_exp_pkg.sv
// Shared types and constants for the modular exponentiation engine.
// The FSM encoding and multiply-phase length live here so the top and its bench agree.
package mod_exp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_REDUCE = 3'd2,
    ST_MUL    = 3'd3,
    ST_SQR    = 3'd4,
    ST_FINISH = 3'd5
  } state_e;

  // A multiply phase is one launch cycle, WIDTH iterations and one capture cycle.
  localparam int unsigned MULT_OVERHEAD = 2;

  function automatic int unsigned mult_cycles(input int unsigned width);
    return width + MULT_OVERHEAD;
  endfunction

endpackage

// File: rtl/mod_mult.sv
// Interleaved shift-add modular multiplier: p = a*b mod n, MSB-first over a.
// Requires b < n; a is unrestricted. done pulses WIDTH+1 cycles after start.
module mod_mult #(
  parameter int WIDTH = 128,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] p,
  output logic             done
);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d, r_q, r_d, p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH+1:0] sum;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    n_d    = n_q;
    r_d    = r_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    // 2r + b < 3n, so two conditional subtractions restore r < n.
    sum = {1'b0, r_q, 1'b0} + (a_q[WIDTH-1] ? {2'b00, b_q} : '0);
    if (sum >= {2'b00, n_q}) sum = sum - {2'b00, n_q};
    if (sum >= {2'b00, n_q}) sum = sum - {2'b00, n_q};
    if (start) begin
      a_d   = a;
      b_d   = b;
      n_d   = n;
      r_d   = '0;
      cnt_d = CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      a_d   = a_q << 1;
      r_d   = sum[WIDTH-1:0];
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        p_d    = sum[WIDTH-1:0];
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      r_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      n_q    <= n_d;
      r_q    <= r_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign p    = p_q;
  assign done = done_q;

endmodule

// File: rtl/mod_exp_engine.sv
// Right-to-left square-and-multiply modular exponentiator, result = base^exponent mod modulus.
// Every multiply phase has a fixed length, so latency depends only on the exponent.
module mod_exp_engine
  import mod_exp_pkg::*;
#(
  parameter int WIDTH     = 128,
  parameter int EXP_WIDTH = 128,
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic [WIDTH-1:0]     result,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     b_q, b_d, n_q, n_d, acc_q, acc_d, result_q, result_d;
  logic [EXP_WIDTH-1:0] e_q, e_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                 mstart_q, mstart_d;
  logic [WIDTH-1:0]     m_a, m_b, m_p;
  logic                 m_done;

  // REDUCE multiplies by 1 so an unreduced base only ever appears on the unrestricted port.
  always_comb begin
    case (state_q)
      ST_REDUCE: begin m_a = b_q;   m_b = ONE; end
      ST_MUL:    begin m_a = acc_q; m_b = b_q; end
      default:   begin m_a = b_q;   m_b = b_q; end
    endcase
  end

  mod_mult #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mult (
    .clk   (clk),
    .reset (reset),
    .start (mstart_q),
    .a     (m_a),
    .b     (m_b),
    .n     (n_q),
    .p     (m_p),
    .done  (m_done)
  );

  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    e_d      = e_q;
    n_d      = n_q;
    acc_d    = acc_q;
    result_d = result_q;
    busy_d   = busy_q;
    err_d    = err_q;
    done_d   = 1'b0;
    mstart_d = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        b_d     = base;
        e_d     = exponent;
        n_d     = modulus;
        err_d   = 1'b0;
        busy_d  = 1'b1;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        acc_d = ONE;
        if (n_q == '0 || n_q == ONE || e_q == '0) begin
          err_d    = (n_q == '0);
          result_d = (n_q == '0 || n_q == ONE) ? '0 : ONE;
          done_d   = 1'b1;
          state_d  = ST_FINISH;
        end else begin
          mstart_d = 1'b1;
          state_d  = ST_REDUCE;
        end
      end
      // e is nonzero here, so a clear LSB always leaves a nonzero shifted exponent.
      ST_REDUCE, ST_SQR: if (m_done) begin
        b_d      = m_p;
        mstart_d = 1'b1;
        if (e_q[0]) begin
          state_d = ST_MUL;
        end else begin
          e_d     = e_q >> 1;
          state_d = ST_SQR;
        end
      end
      ST_MUL: if (m_done) begin
        acc_d = m_p;
        e_d   = e_q >> 1;
        if ((e_q >> 1) == '0) begin
          result_d = m_p;
          done_d   = 1'b1;
          state_d  = ST_FINISH;
        end else begin
          mstart_d = 1'b1;
          state_d  = ST_SQR;
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      b_q      <= '0;
      e_q      <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      e_q      <= e_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mstart_q <= mstart_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mod_exp_engine.sv
// Bench for mod_exp_engine: a 16-bit instance for directed cases and a 128-bit instance
// for random vectors, both scored against a wide-arithmetic reference.
module tb_mod_exp_engine;

  localparam int LIMIT = 40000;

  logic         clk = 1'b0;
  logic         rst;
  logic         st0, st1;
  logic [15:0]  b0, e0, n0, r0;
  logic         bz0, dn0, er0;
  logic [127:0] b1, e1, n1, r1;
  logic         bz1, dn1, er1;
  int           n_chk = 0;
  int           n_pass = 0;

  always #5 clk = ~clk;

  mod_exp_engine #(.WIDTH(16), .EXP_WIDTH(16)) dut0 (
    .clk(clk), .reset(rst), .start(st0), .base(b0), .exponent(e0), .modulus(n0),
    .result(r0), .busy(bz0), .done(dn0), .err(er0)
  );

  mod_exp_engine #(.WIDTH(128), .EXP_WIDTH(128)) dut1 (
    .clk(clk), .reset(rst), .start(st1), .base(b1), .exponent(e1), .modulus(n1),
    .result(r1), .busy(bz1), .done(dn1), .err(er1)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] ref_pow(input logic [127:0] b, input logic [127:0] e,
                                           input logic [127:0] n);
    logic [255:0] r, x, nn;
    if (n == 128'd0 || n == 128'd1) return 128'd0;
    nn = {128'd0, n};
    r  = 256'd1;
    x  = {128'd0, b} % nn;
    for (int i = 0; i < 128; i++) begin
      if (e[i]) r = (r * x) % nn;
      x = (x * x) % nn;
    end
    return r[127:0];
  endfunction

  function automatic int ref_lat(input int w, input logic [127:0] e, input logic [127:0] n);
    int pop, len;
    if (n <= 128'd1 || e == 128'd0) return 2;
    pop = 0;
    len = 0;
    for (int i = 0; i < 128; i++) if (e[i]) begin pop++; len = i + 1; end
    return 2 + (w + 2) * (pop + len);
  endfunction

  function automatic logic cur_done(input int d); return (d == 0) ? dn0 : dn1; endfunction
  function automatic logic cur_busy(input int d); return (d == 0) ? bz0 : bz1; endfunction
  function automatic logic cur_err(input int d);  return (d == 0) ? er0 : er1; endfunction
  function automatic logic [127:0] cur_res(input int d);
    return (d == 0) ? {112'd0, r0} : r1;
  endfunction

  task automatic drive(input int d, input logic s, input logic [127:0] b,
                       input logic [127:0] e, input logic [127:0] n);
    if (d == 0) begin st0 = s; b0 = b[15:0]; e0 = e[15:0]; n0 = n[15:0]; end
    else begin st1 = s; b1 = b; e1 = e; n1 = n; end
  endtask

  // Starts one operation in the cycle after the call, optionally scrambling start and
  // the operands while busy, then scores result, err, latency and busy.
  task automatic run_op(input int d, input logic [127:0] b_in, input logic [127:0] e_in,
                        input logic [127:0] n_in, input bit noise, output logic [127:0] res);
    logic [127:0] b, e, n, rnd;
    int           cyc, w;
    bit           busy_gap;
    w = (d == 0) ? 16 : 128;
    b = (d == 0) ? {112'd0, b_in[15:0]} : b_in;
    e = (d == 0) ? {112'd0, e_in[15:0]} : e_in;
    n = (d == 0) ? {112'd0, n_in[15:0]} : n_in;
    @(negedge clk);
    chk("idle_done", 128'(cur_done(d)), 128'd0);
    chk("idle_busy", 128'(cur_busy(d)), 128'd0);
    drive(d, 1'b1, b, e, n);
    @(negedge clk);
    drive(d, 1'b0, b, e, n);
    cyc = 1;
    busy_gap = 1'b0;
    forever begin
      if (cur_done(d) || cyc >= LIMIT) break;
      if (!cur_busy(d)) busy_gap = 1'b1;
      if (noise) begin
        rnd = {$urandom, $urandom, $urandom, $urandom};
        drive(d, 1'($urandom), rnd, {rnd[63:0], rnd[127:64]}, ~rnd);
      end
      @(negedge clk);
      cyc++;
    end
    drive(d, 1'b0, b, e, n);
    res = cur_res(d);
    chk("done_seen", 128'(cur_done(d)), 128'd1);
    chk("latency", 128'(cyc), 128'(ref_lat(w, e, n)));
    chk("busy_run", 128'(busy_gap), 128'd0);
    chk("busy_done", 128'(cur_busy(d)), 128'd1);
    chk("result", res, ref_pow(b, e, n));
    chk("err", 128'(cur_err(d)), 128'(n == 128'd0));
  endtask

  initial begin
    logic [127:0] res, rb, re, rn, ones;
    int           len;
    bit           saw;
    rst = 1'b1;
    drive(0, 1'b0, 0, 0, 0);
    drive(1, 1'b0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_state0", {112'd0, r0, bz0, dn0, er0}, 128'd0);
    chk("rst_state1", {r1[124:0], bz1, dn1, er1}, 128'd0);
    rst = 1'b0;

    run_op(0, 4, 13, 497, 1'b1, res);          chk("pow_4_13", res, 128'd445);
    run_op(0, 65, 17, 3233, 1'b0, res);        chk("rsa_enc", res, 128'd2790);
    run_op(0, 2790, 2753, 3233, 1'b1, res);    chk("rsa_dec", res, 128'd65);
    run_op(0, 123, 45, 0, 1'b1, res);          chk("n0_res", res, 128'd0);
    run_op(0, 123, 45, 1, 1'b1, res);          chk("n1_res", res, 128'd0);
    run_op(0, 123, 0, 497, 1'b1, res);         chk("e0_res", res, 128'd1);
    run_op(0, 1000, 1, 497, 1'b1, res);        chk("reduce", res, 128'd6);

    // Abort in the first square phase; no done may follow and busy must drop.
    @(negedge clk);
    drive(0, 1'b1, 4, 13, 497);
    @(negedge clk);
    drive(0, 1'b0, 4, 13, 497);
    repeat (44) @(negedge clk);
    chk("mid_busy", 128'(bz0), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 128'(bz0), 128'd0);
    chk("abort_done", 128'(dn0), 128'd0);
    saw = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (dn0 || bz0) saw = 1'b1;
    end
    chk("abort_quiet", 128'(saw), 128'd0);
    run_op(0, 4, 13, 497, 1'b1, res);          chk("post_rst", res, 128'd445);

    for (int i = 0; i < 20; i++) begin
      rn = 128'($urandom_range(0, 65535));
      rb = 128'($urandom_range(0, 65535));
      re = 128'($urandom_range(0, 65535));
      run_op(0, rb, re, rn, 1'b1, res);
    end

    ones = '1;
    for (int i = 0; i < 5; i++) begin
      rn = {$urandom, $urandom, $urandom, $urandom} | 128'd1;
      rb = {$urandom, $urandom, $urandom, $urandom};
      re = {$urandom, $urandom, $urandom, $urandom};
      if (i != 0) begin
        len = $urandom_range(1, 24);
        re = re & (ones >> (128 - len));
      end
      run_op(1, rb, re, rn, 1'b1, res);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
